order_queue: RTL and testbench
==============================

# order_queue

Parametrised single-clock queue for packed layer orders. It sits between the register-file order writer and the layer sequencer in the `system_clk` domain. Compared with the dual-clock order cache, it has configurable width and depth, and a registered first-word-fall-through output with a valid/pop handshake. It also adds occupancy reporting, a configurable almost-full margin, synchronous flush, and sticky overflow/underflow error flags.

## Interface

Parameters:
- `DATA_WIDTH`, default 256: packed order word width.
- `DEPTH`, default 16: total capacity in words, counting the output register. Power of two, ≥ 2.
- `AFULL_MARGIN`, default 1: free slots reserved for upstream latency. Range 0 to `DEPTH`-1.

Ports (clock and reset first):
- `system_clk`, in, 1: the only clock.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `flush`, in, 1: synchronous queue clear.
- `push_order_en`, in, 1: write strobe for `order_in`.
- `order_in`, in, `DATA_WIDTH`: order word to enqueue.
- `order_in_ready`, out, 1: upstream may push; equals `level < DEPTH-AFULL_MARGIN`.
- `order_valid`, out, 1: `order_out` holds the head order.
- `pop_order_en`, in, 1: consumer takes the head word.
- `order_out`, out, `DATA_WIDTH`: head order word, registered.
- `level`, out, `$clog2(DEPTH)+1`: number of stored words, counting the output register.
- `overflow_err`, out, 1: sticky; set when a push is dropped.
- `underflow_err`, out, 1: sticky; set when a pop arrives with no valid word.

## Operation

- Storage is a `DEPTH`-1 entry circular buffer plus the `order_out` head register. Head and tail pointers wrap modulo `DEPTH`-1.
- Push is accepted iff `push_order_en & ~flush & (level < DEPTH)`.
  - The pop in the same cycle is not considered; a push at `level==DEPTH` is dropped even with a simultaneous pop.
  - `order_in_ready` is advisory only. A push with ready low but `level<DEPTH` is still accepted.
- Pop is accepted iff `pop_order_en & order_valid & ~flush`.
- Head register update:
  - If pop is accepted and the buffer is non-empty, `order_out` loads the oldest buffer entry.
  - If the head is empty, or being popped with the buffer empty, an accepted push loads `order_out` directly (bypass).
  - Otherwise an accepted push is written at the tail pointer.
- `level` next value = `level` + push accepted − pop accepted.
- `order_valid` is high iff `level > 0`.
- Flush, when high:
  - `level`, both pointers and `order_valid` go to 0.
  - `order_out` keeps its stale value.
  - `overflow_err` and `underflow_err` clear.
  - Push and pop in the same cycle are ignored and raise no error.
- Error flags:
  - `overflow_err` sets on `push_order_en & ~flush & level==DEPTH`.
  - `underflow_err` sets on `pop_order_en & ~order_valid & ~flush`.
  - Both hold until flush or reset.
- Word order is strictly FIFO. No reordering, and no field is decoded.

## Timing

- Reset (`rst_n` low, async) drives: `order_out`=0, `order_valid`=0, `level`=0, `order_in_ready`=1, `overflow_err`=0, `underflow_err`=0, pointers=0. Any in-flight data is discarded.
- All outputs are registered, except `order_in_ready`, which is combinational from the `level` register.
- Push→valid latency is 1 cycle: a push at edge N into an empty queue gives `order_valid`=1 and `order_out`=data after edge N.
- Pop→next word latency is 1 cycle: after an accepted pop at edge N, the next word (or `order_valid`=0) is visible after edge N.
- Sustained push+pop every cycle at `level==1` gives 1 word per cycle, with `order_valid` held high.
- Deassertion of `rst_n` takes effect at the first `system_clk` edge after release. The release must be synchronised externally.

## Test plan

- Reset, then with `DEPTH`=16, push 0x01..0x03 one per cycle and pop continuously → `order_valid` goes high 1 cycle after the first push; `order_out` shows 0x01, 0x02, 0x03 on consecutive cycles; `level` ends at 0.
- Push 16 words with no pop → `level`=16 and `order_in_ready`=0 from `level`=15 (`AFULL_MARGIN`=1). A 17th push is dropped and `overflow_err`=1. The pops then return words 1..16 in order.
- At `level`=1, assert push(0xAA) and pop together for 5 cycles with data 0xAA..0xAE → `order_out` steps through one word per cycle, `level` stays 1, `order_valid` never drops.
- Fill to `level`=16, then push+pop in the same cycle → the pop is accepted, the push is dropped, `overflow_err`=1, `level`=15.
- With `level`=5, assert flush together with push+pop → after the edge `level`=0, `order_valid`=0 and both error flags are 0. The next push of 0x55 appears at `order_out` 1 cycle later.
- Pop on an empty queue → `underflow_err`=1 and `level` stays 0. Asserting `rst_n`=0 mid-stream at `level`=7 → all outputs go to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/order_queue.sv
// Single-clock FIFO for packed layer orders with a registered first-word-fall-through head,
// occupancy reporting, almost-full ready, synchronous flush and sticky overflow/underflow flags.
module order_queue #(
   parameter int unsigned DATA_WIDTH   = 256,
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned AFULL_MARGIN = 1
) (
   input  logic                        system_clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic                        push_order_en,
   input  logic [DATA_WIDTH-1:0]       order_in,
   output logic                        order_in_ready,
   output logic                        order_valid,
   input  logic                        pop_order_en,
   output logic [DATA_WIDTH-1:0]       order_out,
   output logic [$clog2(DEPTH):0]      level,
   output logic                        overflow_err,
   output logic                        underflow_err
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;
   localparam int unsigned PW = $clog2(DEPTH);

   localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
   localparam logic [LW-1:0] READY_LIM = LW'(DEPTH - AFULL_MARGIN);
   localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 2);

   logic [DATA_WIDTH-1:0] mem [DEPTH-1];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;

   logic                  push_acc;
   logic                  pop_acc;
   logic                  buf_nonempty;
   logic                  load_from_buf;
   logic                  bypass;
   logic                  write_buf;
   logic [LW-1:0]         level_nxt;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // The head register counts toward level, so the buffer holds level-1 words when valid.
   always_comb begin
      push_acc      = push_order_en & ~flush & (level < FULL_LVL);
      pop_acc       = pop_order_en & order_valid & ~flush;
      buf_nonempty  = level > LW'(1);
      load_from_buf = pop_acc & buf_nonempty;
      bypass        = push_acc & (~order_valid | (pop_acc & ~buf_nonempty));
      write_buf     = push_acc & ~bypass;
      level_nxt     = level + {{(LW-1){1'b0}}, push_acc} - {{(LW-1){1'b0}}, pop_acc};
   end

   assign order_in_ready = level < READY_LIM;

   always_ff @(posedge system_clk) begin
      if (write_buf) mem[wr_ptr] <= order_in;
   end

   always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (load_from_buf) rd_ptr <= ptr_inc(rd_ptr);
         if (write_buf)     wr_ptr <= ptr_inc(wr_ptr);
      end
   end

   // Flush leaves the head register stale; only level/valid mark it empty.
   always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
         order_out <= '0;
      end else if (load_from_buf) begin
         order_out <= mem[rd_ptr];
      end else if (bypass) begin
         order_out <= order_in;
      end
   end

   always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
         level       <= '0;
         order_valid <= 1'b0;
      end else if (flush) begin
         level       <= '0;
         order_valid <= 1'b0;
      end else begin
         level       <= level_nxt;
         order_valid <= (level_nxt != '0);
      end
   end

   always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else if (flush) begin
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         if (push_order_en && (level == FULL_LVL)) overflow_err  <= 1'b1;
         if (pop_order_en && !order_valid)          underflow_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_order_queue.sv
// Self-checking bench for order_queue: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based reference model.
module tb_order_queue;

   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int AFM   = 1;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          system_clk;
   logic          rst_n;
   logic          flush;
   logic          push_order_en;
   logic [DW-1:0] order_in;
   logic          order_in_ready;
   logic          order_valid;
   logic          pop_order_en;
   logic [DW-1:0] order_out;
   logic [LW-1:0] level;
   logic          overflow_err;
   logic          underflow_err;

   order_queue #(
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .AFULL_MARGIN(AFM)
   ) dut (
      .system_clk    (system_clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .push_order_en (push_order_en),
      .order_in      (order_in),
      .order_in_ready(order_in_ready),
      .order_valid   (order_valid),
      .pop_order_en  (pop_order_en),
      .order_out     (order_out),
      .level         (level),
      .overflow_err  (overflow_err),
      .underflow_err (underflow_err)
   );

   initial system_clk = 1'b0;
   always #5 system_clk = ~system_clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of stored words plus the two sticky flags.
   logic [DW-1:0] mq[$];
   bit            m_ovf;
   bit            m_udf;
   int            m_n;

   always @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_ovf = 0;
         m_udf = 0;
      end else if (flush) begin
         mq.delete();
         m_ovf = 0;
         m_udf = 0;
      end else begin
         m_n = mq.size();
         if (push_order_en && m_n == DEPTH) m_ovf = 1;
         if (pop_order_en && m_n == 0)      m_udf = 1;
         if (pop_order_en && m_n > 0)       void'(mq.pop_front());
         if (push_order_en && m_n < DEPTH)  mq.push_back(order_in);
      end
   end

   bit chk_en = 0;

   always @(negedge system_clk) begin
      if (chk_en) begin
         check("m_level", 32'(level), 32'(mq.size()));
         check("m_valid", 32'(order_valid), 32'(mq.size() > 0));
         check("m_ready", 32'(order_in_ready), 32'(mq.size() < DEPTH - AFM));
         check("m_ovf", 32'(overflow_err), 32'(m_ovf));
         check("m_udf", 32'(underflow_err), 32'(m_udf));
         if (mq.size() > 0) check("m_head", 32'(order_out), 32'(mq[0]));
      end
   end

   task automatic step(input bit p, input logic [DW-1:0] d, input bit po, input bit f);
      push_order_en = p;
      order_in      = d;
      pop_order_en  = po;
      flush         = f;
      @(posedge system_clk);
      #1;
      push_order_en = 1'b0;
      pop_order_en  = 1'b0;
      flush         = 1'b0;
   endtask

   initial begin
      rst_n         = 1'b0;
      flush         = 1'b0;
      push_order_en = 1'b0;
      pop_order_en  = 1'b0;
      order_in      = '0;
      repeat (2) @(posedge system_clk);
      #1;
      check("rst_level", 32'(level), 32'd0);
      check("rst_valid", 32'(order_valid), 32'd0);
      check("rst_out", 32'(order_out), 32'd0);
      check("rst_ready", 32'(order_in_ready), 32'd1);
      check("rst_errs", {30'd0, overflow_err, underflow_err}, 32'd0);
      rst_n  = 1'b1;
      chk_en = 1;

      // Basic push then push+pop streaming
      step(1, 16'h01, 0, 0);
      check("t1_valid", 32'(order_valid), 32'd1);
      check("t1_out1", 32'(order_out), 32'h01);
      step(1, 16'h02, 1, 0);
      check("t1_out2", 32'(order_out), 32'h02);
      step(1, 16'h03, 1, 0);
      check("t1_out3", 32'(order_out), 32'h03);
      step(0, 0, 1, 0);
      check("t1_level", 32'(level), 32'd0);
      check("t1_empty", 32'(order_valid), 32'd0);

      // Fill, overflow, full push+pop, drain
      for (int i = 1; i <= 16; i++) begin
         step(1, DW'(i), 0, 0);
         if (i == 14) check("t2_ready14", 32'(order_in_ready), 32'd1);
         if (i == 15) check("t2_ready15", 32'(order_in_ready), 32'd0);
      end
      check("t2_full", 32'(level), 32'd16);
      step(1, 16'd17, 0, 0);
      check("t2_ovf", 32'(overflow_err), 32'd1);
      check("t2_lvl16", 32'(level), 32'd16);
      check("t2_head", 32'(order_out), 32'd1);
      step(1, 16'd18, 1, 0);
      check("t2_lvl15", 32'(level), 32'd15);
      check("t2_head2", 32'(order_out), 32'd2);
      for (int i = 2; i <= 16; i++) begin
         check("t2_drain", 32'(order_out), 32'(i));
         step(0, 0, 1, 0);
      end
      check("t2_lvl0", 32'(level), 32'd0);
      step(0, 0, 0, 1);
      check("t2_flush_ovf", 32'(overflow_err), 32'd0);

      // Sustained push+pop at level 1
      step(1, 16'h10, 0, 0);
      for (int k = 0; k < 5; k++) begin
         step(1, DW'(16'hAA + k), 1, 0);
         check("t3_out", 32'(order_out), 32'(16'hAA + k));
         check("t3_lvl", 32'(level), 32'd1);
         check("t3_valid", 32'(order_valid), 32'd1);
      end
      step(0, 0, 1, 0);

      // Underflow, then flush with push+pop
      step(0, 0, 1, 0);
      check("t5_udf", 32'(underflow_err), 32'd1);
      check("t5_lvl0", 32'(level), 32'd0);
      for (int i = 0; i < 5; i++) step(1, DW'(16'h20 + i), 0, 0);
      check("t5_lvl5", 32'(level), 32'd5);
      step(1, 16'h99, 1, 1);
      check("t5_fl_lvl", 32'(level), 32'd0);
      check("t5_fl_valid", 32'(order_valid), 32'd0);
      check("t5_fl_errs", {30'd0, overflow_err, underflow_err}, 32'd0);
      step(1, 16'h55, 0, 0);
      check("t5_out55", 32'(order_out), 32'h55);
      check("t5_valid55", 32'(order_valid), 32'd1);
      step(0, 0, 1, 0);

      // Asynchronous reset mid-stream
      for (int i = 0; i < 7; i++) step(1, DW'(16'h70 + i), 0, 0);
      check("t6_lvl7", 32'(level), 32'd7);
      #2 rst_n = 1'b0;
      #1;
      check("t6_lvl", 32'(level), 32'd0);
      check("t6_valid", 32'(order_valid), 32'd0);
      check("t6_out", 32'(order_out), 32'd0);
      check("t6_ready", 32'(order_in_ready), 32'd1);
      @(posedge system_clk);
      #1 rst_n = 1'b1;

      // Random traffic at three load points
      for (int ph = 0; ph < 3; ph++) begin
         int pp;
         pp = 30 + ph * 25;
         repeat (1500) begin
            step($urandom_range(0, 99) < pp, DW'($urandom),
                 $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 2);
         end
      end

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
